// File: rtl/tse_phy_speed_poller.sv
// tse_phy_speed_poller
//   Autonomous clause-22 MDIO master. It periodically reads the PHY-specific
//   status register of an 88E1111-style PHY, decodes the resolved link, speed
//   and duplex, and drives the TSE MAC status-connection inputs set_10 and
//   set_1000, so RGMII speed follows autonegotiation without CPU help.
//   It owns a dedicated MDIO pin set.
//
// Ports
//   clk_clk      single clock
//   reset_reset  synchronous, active-high reset (mdio_oen is also forced high
//                combinationally while it is asserted)
//   enable       allows polling
//   poll_now     one-cycle request to start a frame immediately
//   mdio_mdc     management clock, period 2*CLK_DIV clocks, low when idle
//   mdio_in      sampled MDIO pad
//   mdio_out     driven MDIO value
//   mdio_oen     active-low output enable (0 = drive)
//   set_10       to MAC status set_10
//   set_1000     to MAC status set_1000
//   link_up      PHY reports link
//   duplex_full  PHY reports full duplex
//   poll_done    one-cycle pulse at the end of every frame
//   rd_error     one-cycle pulse with poll_done when the frame was bad
//   err_cnt      saturating count of bad frames
module tse_phy_speed_poller #(
  parameter int         CLK_DIV       = 25,
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter logic [4:0] STATUS_REG    = 5'd17,
  parameter int         POLL_INTERVAL = 1000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       enable,
  input  logic       poll_now,
  output logic       mdio_mdc,
  input  logic       mdio_in,
  output logic       mdio_out,
  output logic       mdio_oen,
  output logic       set_10,
  output logic       set_1000,
  output logic       link_up,
  output logic       duplex_full,
  output logic       poll_done,
  output logic       rd_error,
  output logic [7:0] err_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMR_W = $clog2(POLL_INTERVAL + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(POLL_INTERVAL);
  // Frame bits 32..45: ST, OP (read), PHY address, register address.
  localparam logic [13:0] HDR = {2'b01, 2'b10, PHY_ADDR, STATUS_REG};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_idx;
  logic [TMR_W-1:0] timer;
  logic [15:0]      rx_data;
  logic             ta_err;
  logic             mdc_q;
  logic             oen_q;

  logic div_wrap, mdc_rise, mdc_fall, last_fall, start_req;
  logic do_start, do_update, do_wait;

  // Value driven for a given frame bit: preamble ones, then the header,
  // then ones while the line is released.
  function automatic logic tx_bit(input logic [5:0] idx);
    if (idx < 6'd32)      return 1'b1;
    else if (idx < 6'd46) return HDR[4'd13 - idx[3:0]];
    else                  return 1'b1;
  endfunction

  // The master drives bits 0..45; from the first TA bit on the PHY owns the line.
  function automatic logic tx_drive(input logic [5:0] idx);
    return (idx < 6'd46);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign div_wrap  = (state == S_SHIFT) && (div_cnt == DIV_LAST);
  assign mdc_rise  = div_wrap && !mdc_q;
  assign mdc_fall  = div_wrap &&  mdc_q;
  assign last_fall = mdc_fall && (bit_idx == 6'd63);
  assign start_req = enable && ((timer == '0) || poll_now);

  assign mdio_mdc = mdc_q;
  // Release the pad in the same cycle reset is raised, not one clock later.
  assign mdio_oen = oen_q | reset_reset;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_req) state_nxt = S_SHIFT;
      S_SHIFT:  if (last_fall) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_WAIT;
      // The timer reaches zero in the same clock the FSM returns to IDLE.
      S_WAIT:   if (poll_now || (timer <= TMR_W'(1))) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    do_start  = 1'b0;
    do_update = 1'b0;
    do_wait   = 1'b0;
    case (state)
      S_IDLE:   do_start  = start_req;
      S_UPDATE: do_update = 1'b1;
      S_WAIT:   do_wait   = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      div_cnt     <= '0;
      bit_idx     <= '0;
      timer       <= '0;
      rx_data     <= '0;
      ta_err      <= 1'b0;
      mdc_q       <= 1'b0;
      oen_q       <= 1'b1;
      mdio_out    <= 1'b1;
      set_10      <= 1'b0;
      set_1000    <= 1'b0;
      link_up     <= 1'b0;
      duplex_full <= 1'b0;
      poll_done   <= 1'b0;
      rd_error    <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      poll_done <= 1'b0;
      rd_error  <= 1'b0;

      // Frame start: bit 0 goes onto the line immediately, MDC starts low.
      if (do_start) begin
        div_cnt  <= '0;
        bit_idx  <= '0;
        mdc_q    <= 1'b0;
        ta_err   <= 1'b0;
        mdio_out <= tx_bit(6'd0);
        oen_q    <= ~tx_drive(6'd0);
      end

      // Shift: sample on MDC rise, advance and drive on MDC fall.
      if (state == S_SHIFT) begin
        if (div_wrap) begin
          div_cnt <= '0;
          mdc_q   <= ~mdc_q;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        if (mdc_rise) begin
          if ((bit_idx == 6'd47) && mdio_in) ta_err <= 1'b1;
          if (bit_idx >= 6'd48) rx_data <= {rx_data[14:0], mdio_in};
        end
        if (mdc_fall) begin
          if (bit_idx == 6'd63) begin
            mdio_out <= 1'b1;
            oen_q    <= 1'b1;
          end else begin
            bit_idx  <= bit_idx + 6'd1;
            mdio_out <= tx_bit(bit_idx + 6'd1);
            oen_q    <= ~tx_drive(bit_idx + 6'd1);
          end
        end
      end

      // Update: the only place status outputs change.
      if (do_update) begin
        poll_done <= 1'b1;
        timer     <= TMR_LOAD;
        if (ta_err || (rx_data[11] && (rx_data[15:14] == 2'b11))) begin
          rd_error <= 1'b1;
          err_cnt  <= sat_inc(err_cnt);
        end else if (!rx_data[11]) begin
          // Speed/duplex not resolved: keep the last MAC speed.
          link_up     <= 1'b0;
          duplex_full <= 1'b0;
        end else begin
          link_up     <= rx_data[10];
          duplex_full <= rx_data[13];
          set_1000    <= (rx_data[15:14] == 2'b10);
          set_10      <= (rx_data[15:14] == 2'b00);
        end
      end

      // Wait: poll_now short-circuits the interval.
      if (do_wait) begin
        if (poll_now) timer <= '0;
        else          timer <= timer - TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tse_phy_speed_poller.sv
`timescale 1ns/1ps
module tb_tse_phy_speed_poller;

  localparam int         CLK_DIV       = 2;
  localparam logic [4:0] PHY_ADDR      = 5'd0;
  localparam logic [4:0] STATUS_REG    = 5'd17;
  localparam int         POLL_INTERVAL = 100;
  localparam int         FRAME_LAT     = 128 * CLK_DIV + 1;
  localparam int         START_GAP     = POLL_INTERVAL + FRAME_LAT + 1;
  localparam logic [45:0] EXP_HDR      = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, STATUS_REG};

  logic       clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       enable = 1'b0;
  logic       poll_now = 1'b0;
  logic       mdio_in = 1'b1;
  logic       mdio_mdc, mdio_out, mdio_oen;
  logic       set_10, set_1000, link_up, duplex_full, poll_done, rd_error;
  logic [7:0] err_cnt;

  tse_phy_speed_poller #(
    .CLK_DIV(CLK_DIV), .PHY_ADDR(PHY_ADDR), .STATUS_REG(STATUS_REG), .POLL_INTERVAL(POLL_INTERVAL)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .enable(enable), .poll_now(poll_now),
    .mdio_mdc(mdio_mdc), .mdio_in(mdio_in), .mdio_out(mdio_out), .mdio_oen(mdio_oen),
    .set_10(set_10), .set_1000(set_1000), .link_up(link_up), .duplex_full(duplex_full),
    .poll_done(poll_done), .rd_error(rd_error), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rd_err;
    logic       link;
    logic       dup;
    logic       s10;
    logic       s1000;
    logic [7:0] ec;
  } stat_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  logic  rst_at_edge = 1'b1;
  stat_t exp_q[$];
  stat_t model_st = '0;

  // PHY register content offered to the next frame, latched at frame start.
  logic [15:0] phy_val = 16'h0000;
  bit          phy_ta_ok = 1'b1;
  logic [15:0] cur_val = 16'h0000;
  bit          cur_ta = 1'b1;

  int          rx_bit = 0;
  bit          in_frame = 1'b0;
  int          last_start = 0;
  int          n_starts = 0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset_reset;
  end

  // Reference: speed code 0 = 10M, 1 = 100M, 2 = 1000M, 3 = reserved.
  function automatic stat_t model(input stat_t cur, input logic [15:0] v, input bit ta_ok);
    stat_t n;
    int    speed;
    n = cur;
    n.rd_err = 1'b0;
    speed = int'(v[15:14]);
    if (!ta_ok || (v[11] && speed == 3)) begin
      n.rd_err = 1'b1;
      n.ec = (int'(cur.ec) < 255) ? cur.ec + 8'd1 : 8'd255;
    end else if (!v[11]) begin
      n.link = 1'b0;
      n.dup  = 1'b0;
    end else begin
      n.link  = v[10];
      n.dup   = v[13];
      n.s10   = (speed == 0);
      n.s1000 = (speed == 2);
    end
    return n;
  endfunction

  // What the PHY presents for frame bit n (pull-up when nobody drives).
  function automatic logic phy_bit(input int n);
    if (n == 47) return cur_ta ? 1'b0 : 1'b1;
    if (n >= 48 && n <= 63) return cur_val[63 - n];
    return 1'b1;
  endfunction

  // PHY model + output monitor, evaluated on the falling clock edge.
  task automatic monitor();
    logic        oen_prev = 1'b1;
    logic        mdc_prev = 1'b0;
    logic [45:0] cap = '0;
    bit          oen_bad = 1'b0;
    logic [11:0] prev_sv = '0;
    logic [11:0] sv;
    stat_t       e, act;
    forever begin
      @(negedge clk);
      if (oen_prev && !mdio_oen) begin
        in_frame = 1'b1; rx_bit = 0; last_start = cyc; n_starts++;
        cap = '0; oen_bad = 1'b0; cur_val = phy_val; cur_ta = phy_ta_ok;
      end else if (in_frame && mdio_mdc && !mdc_prev) begin
        if (rx_bit < 46) begin
          cap = {cap[44:0], mdio_out};
          if (mdio_oen) oen_bad = 1'b1;
        end
        if (rx_bit == 45) begin
          checks++;
          if ({oen_bad, cap} !== {1'b0, EXP_HDR}) begin
            failures++;
            $display("FAIL hdr: got released=%0b bits=%h, want released=0 bits=%h", oen_bad, cap, EXP_HDR);
          end
        end
        if (rx_bit == 47) begin
          checks++;
          if (mdio_oen !== 1'b1) begin
            failures++;
            $display("FAIL release: mdio_oen=%0b at TA, want 1", mdio_oen);
          end
        end
        rx_bit++;
        mdio_in = phy_bit(rx_bit);
        if (rx_bit >= 64) begin
          in_frame = 1'b0;
          mdio_in = 1'b1;
        end
      end
      oen_prev = mdio_oen;
      mdc_prev = mdio_mdc;

      if (poll_done === 1'b1) begin
        act = {rd_error, link_up, duplex_full, set_10, set_1000, err_cnt};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: poll_done at cycle %0d with nothing expected", cyc);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL status: got rde/link/dup/s10/s1000/ec=%0b%0b%0b%0b%0b/%0d, want %0b%0b%0b%0b%0b/%0d",
                     act.rd_err, act.link, act.dup, act.s10, act.s1000, act.ec,
                     e.rd_err, e.link, e.dup, e.s10, e.s1000, e.ec);
          end
        end
        checks++;
        if (cyc - last_start != FRAME_LAT) begin
          failures++;
          $display("FAIL latency: start-to-done %0d clocks, want %0d", cyc - last_start, FRAME_LAT);
        end
        checks++;
        if (set_10 && set_1000) begin
          failures++;
          $display("FAIL exclusive: set_10=%0b set_1000=%0b, want not both 1", set_10, set_1000);
        end
      end else if (rd_error === 1'b1) begin
        checks++; failures++;
        $display("FAIL rd_error_alone: rd_error=1 without poll_done at cycle %0d", cyc);
      end

      sv = {link_up, duplex_full, set_10, set_1000, err_cnt};
      if (!rst_at_edge && poll_done !== 1'b1) begin
        checks++;
        if (sv !== prev_sv) begin
          failures++;
          $display("FAIL stable: status %h changed to %h outside an update (cycle %0d)", prev_sv, sv, cyc);
        end
      end
      prev_sv = sv;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (poll_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL timeout: no poll_done within 2000 clocks (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_start(input int n0);
    for (int i = 0; i < 1000; i++) begin
      if (n_starts != n0) break;
      @(negedge clk);
    end
  endtask

  task automatic check_reset(input string name);
    logic [16:0] act;
    act = {mdio_mdc, mdio_out, mdio_oen, set_10, set_1000, link_up, duplex_full,
           poll_done, rd_error, err_cnt};
    checks++;
    if (act !== {1'b0, 1'b1, 1'b1, 6'b000000, 8'h00}) begin
      failures++;
      $display("FAIL %s: outputs mdc/out/oen/s10/s1000/link/dup/done/rde/ec=%b, want 011000000_00000000", name, act);
    end
  endtask

  // trig: 0 = release reset/raise enable, 1 = timer expiry, 2 = poll_now in WAIT,
  //       3 = timer expiry with a stray poll_now mid-frame, 4 = timer expiry then enable=0 mid-frame.
  task automatic run_txn(input logic [15:0] val, input bit ta_ok, input int trig, output bit ok);
    stat_t e;
    int    exp_start;
    int    base;
    int    n0;
    phy_val = val;
    phy_ta_ok = ta_ok;
    e = model(model_st, val, ta_ok);
    model_st = e;
    exp_q.push_back(e);
    base = last_start;
    n0 = n_starts;
    exp_start = base + START_GAP;
    case (trig)
      0: begin
        reset_reset = 1'b0;
        enable = 1'b1;
        exp_start = cyc + 1;
      end
      2: begin
        poll_now = 1'b1;
        exp_start = cyc + 2;
        @(negedge clk);
        poll_now = 1'b0;
      end
      3, 4: begin
        wait_start(n0);
        repeat (40) @(negedge clk);
        if (trig == 3) begin
          poll_now = 1'b1;
          @(negedge clk);
          poll_now = 1'b0;
        end else begin
          enable = 1'b0;
        end
      end
      default: ;
    endcase
    wait_done(ok);
    if (ok) begin
      checks++;
      if (last_start != exp_start) begin
        failures++;
        $display("FAIL start: frame started at cycle %0d, want %0d (trigger %0d)", last_start, exp_start, trig);
      end
    end
  endtask

  initial begin
    bit          ok;
    logic [15:0] v;
    int          n0;
    fork
      monitor();
    join_none

    repeat (4) @(negedge clk);
    check_reset("reset_values");

    run_txn(16'hAC00, 1'b1, 0, ok);   // gigabit, full duplex, link
    run_txn(16'h0C00, 1'b1, 1, ok);   // 10 Mb/s, half duplex, link
    run_txn(16'hAC00, 1'b1, 2, ok);
    run_txn(16'h0400, 1'b1, 1, ok);   // unresolved after gigabit
    run_txn(16'hAC00, 1'b0, 3, ok);   // TA not driven, stray poll_now in SHIFT
    run_txn(16'h4C00, 1'b1, 2, ok);   // 100 Mb/s
    run_txn(16'hCC00, 1'b1, 1, ok);   // reserved speed code

    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 3) != 0) v[11] = 1'b1;
      run_txn(v, ($urandom_range(0, 7) != 0), int'($urandom_range(1, 3)), ok);
    end

    // Dropping enable mid-frame lets that frame finish but starts no more.
    run_txn(16'h0C00, 1'b1, 4, ok);
    n0 = n_starts;
    repeat (400) @(negedge clk);
    checks++;
    if (n_starts != n0) begin
      failures++;
      $display("FAIL disabled: %0d frames started while enable=0, want 0", n_starts - n0);
    end
    run_txn(16'h8400, 1'b1, 0, ok);

    // Abort a frame around bit 40 with reset.
    n0 = n_starts;
    wait_start(n0);
    for (int i = 0; i < 300; i++) begin
      if (in_frame && rx_bit >= 40) break;
      @(negedge clk);
    end
    reset_reset = 1'b1;
    #1;
    checks++;
    if (mdio_oen !== 1'b1) begin
      failures++;
      $display("FAIL oen_immediate: mdio_oen=%0b during reset, want 1", mdio_oen);
    end
    @(negedge clk);
    check_reset("abort_reset");
    model_st = '0;
    @(negedge clk);
    run_txn(16'h0C00, 1'b1, 0, ok);

    // Bad-frame counter saturation.
    for (int i = 0; i < 256; i++) begin
      run_txn(16'($urandom), 1'b0, 2, ok);
      if (!ok) break;
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected frames never completed, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
